// File: rtl/coeff_load_sequencer.sv
// ---------------------------------------------------------------------------
// coeff_load_sequencer
//
// Issues NUM_COEFF single-cycle load strobes into a downstream coefficient
// register file or FIR datapath. Each load waits until the datapath's
// modwait flag is low, and consecutive loads are at least 1+WAIT_MIN cycles
// apart. While a set is in progress, one further request can be queued.
// Abort cancels the current set and any queued request.
//
// Optional feature macro: LOAD_TIMEOUT_EN
//   When it is defined, a modwait that stays high for TIMEOUT_CYCLES
//   consecutive WAIT cycles ends the set. The block returns to IDLE and
//   pulses timeout_err.
//   When it is undefined, no timeout counter is built and timeout_err is
//   always 0.
//
// Ports:
//   clk                  system clock, all logic on the rising edge
//   n_reset              synchronous, active-low reset
//   new_coefficient_set  request to load a full set (level or pulse)
//   modwait              datapath busy; no load is issued while it is high
//   abort                cancel the current sequence and any pending request
//   load_coeff           one-cycle strobe per coefficient
//   coefficient_num      index of the coefficient being loaded (0 when idle)
//   busy                 high in LOAD and WAIT
//   load_done            one-cycle pulse after the final load of a set
//   timeout_err          one-cycle pulse on modwait timeout
// ---------------------------------------------------------------------------
module coeff_load_sequencer #(
    parameter int NUM_COEFF      = 4,
    parameter int IDX_W          = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1,
    parameter int WAIT_MIN       = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             new_coefficient_set,
    input  logic             modwait,
    input  logic             abort,
    output logic             load_coeff,
    output logic [IDX_W-1:0] coefficient_num,
    output logic             busy,
    output logic             load_done,
    output logic             timeout_err
);

    localparam int               GAP_W    = $clog2(WAIT_MIN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFF - 1);
    localparam logic [GAP_W-1:0] GAP_MIN  = GAP_W'(WAIT_MIN);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        DONE
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [GAP_W-1:0] gap_cnt, gap_next;
    logic             pending, pending_next;

`ifdef LOAD_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt, tmo_next;
    logic             tmo_err, tmo_err_next;
`endif

    // State register and sequencing counters.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state   <= IDLE;
            idx     <= '0;
            gap_cnt <= '0;
            pending <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            gap_cnt <= gap_next;
            pending <= pending_next;
`ifdef LOAD_TIMEOUT_EN
            tmo_cnt <= tmo_next;
            tmo_err <= tmo_err_next;
`endif
        end
    end

    // Next-state logic. Abort overrides everything, including any request
    // that arrives in the same cycle.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        gap_next     = gap_cnt;
        pending_next = pending;
`ifdef LOAD_TIMEOUT_EN
        tmo_next     = tmo_cnt;
        tmo_err_next = 1'b0;
`endif
        if (abort) begin
            state_next   = IDLE;
            idx_next     = '0;
            gap_next     = '0;
            pending_next = 1'b0;
`ifdef LOAD_TIMEOUT_EN
            tmo_next     = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if ((new_coefficient_set || pending) && !modwait) begin
                        state_next   = LOAD;
                        idx_next     = '0;
                        pending_next = 1'b0;
                    end
                end
                LOAD: begin
                    pending_next = pending || new_coefficient_set;
                    if (idx == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                        gap_next   = GAP_W'(1);
`ifdef LOAD_TIMEOUT_EN
                        tmo_next   = '0;
`endif
                    end
                end
                WAIT: begin
                    pending_next = pending || new_coefficient_set;
                    if (gap_cnt < GAP_MIN) begin
                        gap_next = gap_cnt + GAP_W'(1);
                    end
                    if (gap_cnt >= GAP_MIN && !modwait) begin
                        state_next = LOAD;
                        idx_next   = idx + IDX_W'(1);
                    end
`ifdef LOAD_TIMEOUT_EN
                    // This cycle is the TIMEOUT_CYCLES-th consecutive
                    // busy cycle, so the set is dropped.
                    if (modwait) begin
                        if (tmo_cnt == TMO_LAST) begin
                            state_next   = IDLE;
                            idx_next     = '0;
                            gap_next     = '0;
                            tmo_next     = '0;
                            pending_next = 1'b0;
                            tmo_err_next = 1'b1;
                        end else begin
                            tmo_next = tmo_cnt + TMO_W'(1);
                        end
                    end else begin
                        tmo_next = '0;
                    end
`endif
                end
                DONE: begin
                    pending_next = pending || new_coefficient_set;
                    state_next   = IDLE;
                    idx_next     = '0;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Moore outputs: all are decoded from registered state.
    assign load_coeff      = (state == LOAD);
    assign coefficient_num = (state == LOAD) ? idx : '0;
    assign busy            = (state == LOAD) || (state == WAIT);
    assign load_done       = (state == DONE);

`ifdef LOAD_TIMEOUT_EN
    assign timeout_err = tmo_err;
`else
    // Always 0. The compare only keeps TIMEOUT_CYCLES referenced in this
    // build.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_coeff_load_sequencer.sv
// ---------------------------------------------------------------------------
// tb_coeff_load_sequencer
//
// Directed bench for coeff_load_sequencer with NUM_COEFF=4 and WAIT_MIN=1.
// Each vector drives the inputs for one cycle and compares the packed
// outputs {load_coeff, coefficient_num, busy, load_done, timeout_err}
// against a hand-written expected value.
// ---------------------------------------------------------------------------
module tb_coeff_load_sequencer;

    logic       clk;
    logic       n_reset;
    logic       new_coefficient_set;
    logic       modwait;
    logic       abort;
    logic       load_coeff;
    logic [1:0] coefficient_num;
    logic       busy;
    logic       load_done;
    logic       timeout_err;

    int num_checks = 0;
    int num_errors = 0;
    int cyc        = 0;

    // Expected-output encodings: {load, num[1:0], busy, done, terr}.
    localparam logic [5:0] I = 6'b000000;
    localparam logic [5:0] W = 6'b000100;
    localparam logic [5:0] D = 6'b000010;
    localparam logic [5:0] E = 6'b000001;

    coeff_load_sequencer #(
        .NUM_COEFF      (4),
        .WAIT_MIN       (1),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                 (clk),
        .n_reset             (n_reset),
        .new_coefficient_set (new_coefficient_set),
        .modwait             (modwait),
        .abort               (abort),
        .load_coeff          (load_coeff),
        .coefficient_num     (coefficient_num),
        .busy                (busy),
        .load_done           (load_done),
        .timeout_err         (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected value for a LOAD cycle of coefficient k.
    function automatic logic [5:0] ld(input int k);
        logic [1:0] kk;
        kk = k[1:0];
        return {1'b1, kk, 3'b100};
    endfunction

    // Counts one comparison and reports it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, checks this cycle's outputs, then moves
    // 1 time unit past the next rising edge.
    task automatic applyStimulus(input string name, input logic rn, input logic req,
                                 input logic mw, input logic ab, input logic [5:0] exp);
        n_reset             = rn;
        new_coefficient_set = req;
        modwait             = mw;
        abort               = ab;
        checkOutput($sformatf("%s_c%0d", name, cyc),
                    {26'd0, load_coeff, coefficient_num, busy, load_done, timeout_err},
                    {26'd0, exp});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Holds reset for two edges, checks the reset state, and leaves the
    // bench at cycle 0 with all inputs low.
    task automatic doReset(input string name);
        n_reset             = 1'b0;
        new_coefficient_set = 1'b0;
        modwait             = 1'b0;
        abort               = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;
        cyc     = 0;
        checkOutput({name, "_reset"},
                    {26'd0, load_coeff, coefficient_num, busy, load_done, timeout_err},
                    32'd0);
    endtask

    initial begin
        // Single set: loads in cycles 1,3,5,7, done in cycle 8.
        doReset("single");
        applyStimulus("single", 1, 1, 0, 0, I);
        applyStimulus("single", 1, 0, 0, 0, ld(0));
        applyStimulus("single", 1, 0, 0, 0, W);
        applyStimulus("single", 1, 0, 0, 0, ld(1));
        applyStimulus("single", 1, 0, 0, 0, W);
        applyStimulus("single", 1, 0, 0, 0, ld(2));
        applyStimulus("single", 1, 0, 0, 0, W);
        applyStimulus("single", 1, 0, 0, 0, ld(3));
        applyStimulus("single", 1, 0, 0, 0, D);
        applyStimulus("single", 1, 0, 0, 0, I);
        applyStimulus("single", 1, 0, 0, 0, I);

        // Backpressure: modwait high in cycles 4-8, load of idx2 in cycle 10.
        doReset("bp");
        applyStimulus("bp", 1, 1, 0, 0, I);
        applyStimulus("bp", 1, 0, 0, 0, ld(0));
        applyStimulus("bp", 1, 0, 0, 0, W);
        applyStimulus("bp", 1, 0, 0, 0, ld(1));
        for (int c = 4; c <= 8; c++) applyStimulus("bp", 1, 0, 1, 0, W);
        applyStimulus("bp", 1, 0, 0, 0, W);
        applyStimulus("bp", 1, 0, 0, 0, ld(2));
        applyStimulus("bp", 1, 0, 0, 0, W);
        applyStimulus("bp", 1, 0, 0, 0, ld(3));
        applyStimulus("bp", 1, 0, 0, 0, D);
        applyStimulus("bp", 1, 0, 0, 0, I);

        // Queued request in cycle 4: second set loads idx0 in cycle 10.
        doReset("queue");
        applyStimulus("queue", 1, 1, 0, 0, I);
        applyStimulus("queue", 1, 0, 0, 0, ld(0));
        applyStimulus("queue", 1, 0, 0, 0, W);
        applyStimulus("queue", 1, 0, 0, 0, ld(1));
        applyStimulus("queue", 1, 1, 0, 0, W);
        applyStimulus("queue", 1, 0, 0, 0, ld(2));
        applyStimulus("queue", 1, 0, 0, 0, W);
        applyStimulus("queue", 1, 0, 0, 0, ld(3));
        applyStimulus("queue", 1, 0, 0, 0, D);
        applyStimulus("queue", 1, 0, 0, 0, I);
        for (int k = 0; k < 3; k++) begin
            applyStimulus("queue", 1, 0, 0, 0, ld(k));
            applyStimulus("queue", 1, 0, 0, 0, W);
        end
        applyStimulus("queue", 1, 0, 0, 0, ld(3));
        applyStimulus("queue", 1, 0, 0, 0, D);
        applyStimulus("queue", 1, 0, 0, 0, I);
        applyStimulus("queue", 1, 0, 0, 0, I);

        // Abort in WAIT with a request queued in cycle 2: nothing follows.
        doReset("abort");
        applyStimulus("abort", 1, 1, 0, 0, I);
        applyStimulus("abort", 1, 0, 0, 0, ld(0));
        applyStimulus("abort", 1, 1, 0, 0, W);
        applyStimulus("abort", 1, 0, 0, 0, ld(1));
        applyStimulus("abort", 1, 0, 0, 1, W);
        for (int c = 5; c <= 9; c++) applyStimulus("abort", 1, 0, 0, 0, I);

        // Abort during a LOAD cycle: the strobe is still seen.
        doReset("abload");
        applyStimulus("abload", 1, 1, 0, 0, I);
        applyStimulus("abload", 1, 0, 0, 1, ld(0));
        applyStimulus("abload", 1, 0, 0, 0, I);
        applyStimulus("abload", 1, 0, 0, 0, I);

        // Abort and request together: abort wins, nothing starts.
        doReset("abprio");
        applyStimulus("abprio", 1, 1, 0, 1, I);
        applyStimulus("abprio", 1, 0, 0, 0, I);
        applyStimulus("abprio", 1, 0, 0, 0, I);

        // Level request held off by modwait in IDLE, then released.
        doReset("hold");
        applyStimulus("hold", 1, 1, 1, 0, I);
        applyStimulus("hold", 1, 1, 1, 0, I);
        applyStimulus("hold", 1, 1, 1, 0, I);
        applyStimulus("hold", 1, 1, 0, 0, I);
        applyStimulus("hold", 1, 0, 0, 0, ld(0));
        applyStimulus("hold", 1, 0, 0, 0, W);
        applyStimulus("hold", 1, 0, 0, 0, ld(1));
        applyStimulus("hold", 1, 0, 0, 0, W);
        applyStimulus("hold", 1, 0, 0, 0, ld(2));
        applyStimulus("hold", 1, 0, 0, 0, W);
        applyStimulus("hold", 1, 0, 0, 0, ld(3));
        applyStimulus("hold", 1, 0, 0, 0, D);
        applyStimulus("hold", 1, 0, 0, 0, I);

        // Reset mid-sequence: idle on the next edge with no done pulse.
        doReset("midrst");
        applyStimulus("midrst", 1, 1, 0, 0, I);
        applyStimulus("midrst", 1, 0, 0, 0, ld(0));
        applyStimulus("midrst", 1, 0, 0, 0, W);
        applyStimulus("midrst", 0, 0, 0, 0, ld(1));
        applyStimulus("midrst", 1, 0, 0, 0, I);
        applyStimulus("midrst", 1, 0, 0, 0, I);
        applyStimulus("midrst", 1, 0, 0, 0, I);

`ifdef LOAD_TIMEOUT_EN
        // modwait stuck high after idx0: 8 WAIT cycles, then a single
        // timeout_err pulse in the first IDLE cycle.
        doReset("tmo");
        applyStimulus("tmo", 1, 1, 0, 0, I);
        applyStimulus("tmo", 1, 0, 1, 0, ld(0));
        for (int c = 2; c <= 9; c++) applyStimulus("tmo", 1, 0, 1, 0, W);
        applyStimulus("tmo", 1, 0, 1, 0, E);
        applyStimulus("tmo", 1, 0, 0, 0, I);
        applyStimulus("tmo", 1, 0, 0, 0, I);
`endif

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
